cond_branch_unit: RTL and testbench

COND_BRANCH_UNIT -- requirements
Module: cond_branch_unit

---
 rtl/cond_branch_unit_pkg.sv | 40 ++++
 rtl/cond_branch_unit_cond_eval.sv | 49 ++++
 rtl/cond_branch_unit.sv | 121 ++++++++++++
 tb/tb_cond_branch_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cond_branch_unit_pkg.sv
// rtl/cond_branch_unit_pkg.sv - shared flag indices, condition codes and FSM encoding
// Purpose: definitions shared by cond_branch_unit, cond_eval and any future
//          predicated-instruction logic.
// Ports:   none (package).
package cond_branch_unit_pkg;

  // Bit positions of the architectural flags inside the flag word / PSR
  localparam int FLAG_C    = 0;
  localparam int FLAG_L    = 1;
  localparam int FLAG_F    = 2;
  localparam int FLAG_Z    = 3;
  localparam int FLAG_N    = 4;
  localparam int FLAG_BITS = 5;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,
    COND_NE = 4'd1,
    COND_CS = 4'd2,
    COND_CC = 4'd3,
    COND_HI = 4'd4,
    COND_LS = 4'd5,
    COND_GT = 4'd6,
    COND_LE = 4'd7,
    COND_FS = 4'd8,
    COND_FC = 4'd9,
    COND_LO = 4'd10,
    COND_HS = 4'd11,
    COND_LT = 4'd12,
    COND_GE = 4'd13,
    COND_AL = 4'd14,
    COND_NV = 4'd15
  } cond_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/cond_branch_unit_cond_eval.sv
// rtl/cond_branch_unit_cond_eval.sv - combinational condition-code evaluator
// Purpose: decide whether a 4-bit condition holds for a 5-bit flag set.
// Ports:   i_flags  [4:0]  flag set (C,L,F,Z,N at package indices)
//          i_cond   [3:0]  condition code
//          o_taken         condition is true
module cond_eval
  import cond_branch_unit_pkg::*;
(
  input  logic [FLAG_BITS-1:0] i_flags,
  input  logic [3:0]           i_cond,
  output logic                 o_taken
);

  logic w_c;
  logic w_l;
  logic w_f;
  logic w_z;
  logic w_n;

  assign w_c = i_flags[FLAG_C];
  assign w_l = i_flags[FLAG_L];
  assign w_f = i_flags[FLAG_F];
  assign w_z = i_flags[FLAG_Z];
  assign w_n = i_flags[FLAG_N];

  always_comb begin
    o_taken = 1'b0;
    case (cond_e'(i_cond))
      COND_EQ: o_taken = w_z;
      COND_NE: o_taken = !w_z;
      COND_CS: o_taken = w_c;
      COND_CC: o_taken = !w_c;
      COND_HI: o_taken = w_l;
      COND_LS: o_taken = !w_l;
      COND_GT: o_taken = w_n;
      COND_LE: o_taken = !w_n;
      COND_FS: o_taken = w_f;
      COND_FC: o_taken = !w_f;
      COND_LO: o_taken = !w_l && !w_z;
      COND_HS: o_taken = w_l || w_z;
      COND_LT: o_taken = !w_n && !w_z;
      COND_GE: o_taken = w_n || w_z;
      COND_AL: o_taken = 1'b1;
      COND_NV: o_taken = 1'b0;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_branch_unit.sv
// rtl/cond_branch_unit.sv - conditional branch resolution unit with flag register
// Purpose: accepts one branch request at a time, evaluates its condition
//          against the PSR and returns taken/next_pc through a valid/ready pair.
// Ports:   clk, rst_n                 clock, async active-low reset
//          flag_in, flag_we           PSR load (bits [4:0] used)
//          req_valid/req_ready        request handshake
//          cond, pc, disp, absolute   request payload
//          resp_valid/resp_ready      response handshake
//          taken, next_pc             response payload
//          psr                        current flags, zero-extended
module cond_branch_unit
  import cond_branch_unit_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] flag_in,
  input  logic             flag_we,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       cond,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] disp,
  input  logic             absolute,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             taken,
  output logic [WIDTH-1:0] next_pc,
  output logic [WIDTH-1:0] psr
);

  state_e               r_state;
  logic [FLAG_BITS-1:0] r_psr;
  logic [3:0]           r_cond;
  logic [WIDTH-1:0]     r_pc;
  logic [WIDTH-1:0]     r_disp;
  logic                 r_abs;
  logic                 r_req_ready;
  logic                 r_resp_valid;
  logic                 r_taken;
  logic [WIDTH-1:0]     r_next_pc;

  logic [FLAG_BITS-1:0] w_flags_eval;
  logic                 w_taken;
  logic [WIDTH-1:0]     w_target;
  logic [WIDTH-1:0]     w_seq_pc;
  logic                 w_unused_flag_bits;

  // A flag write landing in the EVAL cycle must be seen by the branch
  // being evaluated, so bypass the PSR with the incoming flags.
  assign w_flags_eval = flag_we ? flag_in[FLAG_BITS-1:0] : r_psr;

  cond_eval u_cond_eval (
    .i_flags (w_flags_eval),
    .i_cond  (r_cond),
    .o_taken (w_taken)
  );

  // Both additions wrap silently at 2^WIDTH.
  assign w_target = r_abs ? r_disp : (r_pc + r_disp);
  assign w_seq_pc = r_pc + WIDTH'(1);

  assign w_unused_flag_bits = ^flag_in[WIDTH-1:FLAG_BITS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_psr        <= '0;
      r_cond       <= '0;
      r_pc         <= '0;
      r_disp       <= '0;
      r_abs        <= 1'b0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_taken      <= 1'b0;
      r_next_pc    <= '0;
    end else begin
      if (flag_we) begin
        r_psr <= flag_in[FLAG_BITS-1:0];
      end
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_cond      <= cond;
            r_pc        <= pc;
            r_disp      <= disp;
            r_abs       <= absolute;
            r_req_ready <= 1'b0;
            r_state     <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          r_taken      <= w_taken;
          r_next_pc    <= w_taken ? w_target : w_seq_pc;
          r_resp_valid <= 1'b1;
          r_state      <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_resp_valid <= 1'b0;
          r_req_ready  <= 1'b1;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign taken      = r_taken;
  assign next_pc    = r_next_pc;
  assign psr        = WIDTH'(r_psr);

endmodule

// File: tb/tb_cond_branch_unit.sv
// tb/tb_cond_branch_unit.sv - scoreboard bench for cond_branch_unit
module tb_cond_branch_unit;

  logic        clk;
  logic        rst_n;
  logic [15:0] flag_in;
  logic        flag_we;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  cond;
  logic [15:0] pc;
  logic [15:0] disp;
  logic        absolute;
  logic        resp_valid;
  logic        resp_ready;
  logic        taken;
  logic [15:0] next_pc;
  logic [15:0] psr;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        taken;
    logic [15:0] next_pc;
  } exp_t;

  exp_t sb_q[$];

  typedef struct {
    logic [15:0] flags;
    logic [3:0]  cc;
    logic        exp;
  } cv_t;

  cond_branch_unit #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flag_in    (flag_in),
    .flag_we    (flag_we),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .cond       (cond),
    .pc         (pc),
    .disp       (disp),
    .absolute   (absolute),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .taken      (taken),
    .next_pc    (next_pc),
    .psr        (psr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per completed response handshake.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && resp_valid && resp_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got taken=%0b next_pc=0x%0h expected no response", taken, next_pc);
      end else begin
        e = sb_q.pop_front();
        check("resp_taken", {31'd0, taken}, {31'd0, e.taken});
        check("resp_next_pc", {16'd0, next_pc}, {16'd0, e.next_pc});
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (req_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_ready: got req_ready=%0b expected 1 within 50 cycles", req_ready);
    end
  endtask

  task automatic load_flags(input logic [15:0] v);
    flag_in = v;
    flag_we = 1'b1;
    @(posedge clk);
    #1;
    flag_we = 1'b0;
  endtask

  // Drives one request and checks the two-edge latency to resp_valid.
  task automatic issue(input logic [3:0] c, input logic [15:0] p, input logic [15:0] d,
                       input logic a, input logic exp_taken, input logic [15:0] exp_pc);
    exp_t e;
    wait_ready();
    cond      = c;
    pc        = p;
    disp      = d;
    absolute  = a;
    req_valid = 1'b1;
    e.taken   = exp_taken;
    e.next_pc = exp_pc;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("lat_edge1_valid", {31'd0, resp_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("lat_edge2_valid", {31'd0, resp_valid}, 32'd1);
  endtask

  cv_t tbl [17] = '{
    '{16'h0002, 4'd4,  1'b1},   // HI, L=1
    '{16'h0002, 4'd5,  1'b0},   // LS
    '{16'h0002, 4'd10, 1'b0},   // LO needs !L&!Z
    '{16'h0002, 4'd11, 1'b1},   // HS
    '{16'h0000, 4'd10, 1'b1},   // LO
    '{16'h0000, 4'd12, 1'b1},   // LT
    '{16'h0000, 4'd13, 1'b0},   // GE
    '{16'h0010, 4'd6,  1'b1},   // GT, N=1
    '{16'h0010, 4'd7,  1'b0},   // LE
    '{16'h0004, 4'd8,  1'b1},   // FS, F=1
    '{16'h0004, 4'd9,  1'b0},   // FC
    '{16'h0001, 4'd2,  1'b1},   // CS, C=1
    '{16'h0001, 4'd3,  1'b0},   // CC
    '{16'h0000, 4'd1,  1'b1},   // NE, Z=0
    '{16'h0008, 4'd13, 1'b1},   // GE via Z
    '{16'h0008, 4'd12, 1'b0},   // LT blocked by Z
    '{16'hFFE0, 4'd0,  1'b0}    // upper bits ignored, Z=0
  };

  initial begin : stim
    logic [15:0] tp;
    rst_n      = 1'b0;
    flag_in    = '0;
    flag_we    = 1'b0;
    req_valid  = 1'b0;
    cond       = '0;
    pc         = '0;
    disp       = '0;
    absolute   = 1'b0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_taken", {31'd0, taken}, 32'd0);
    check("rst_next_pc", {16'd0, next_pc}, 32'd0);
    check("rst_psr", {16'd0, psr}, 32'd0);

    // Basic EQ taken / not taken, always, never
    load_flags(16'h0008);
    check("psr_load", {16'd0, psr}, 32'h0008);
    issue(4'd0, 16'h0010, 16'h0004, 1'b0, 1'b1, 16'h0014);
    load_flags(16'h0000);
    issue(4'd0, 16'h0010, 16'h0004, 1'b0, 1'b0, 16'h0011);
    load_flags(16'h001F);
    issue(4'd15, 16'h0020, 16'h0004, 1'b0, 1'b0, 16'h0021);
    issue(4'd14, 16'h0030, 16'hFFF0, 1'b0, 1'b1, 16'h0020);

    // Wrap and absolute targets
    issue(4'd14, 16'hFFFE, 16'h0004, 1'b0, 1'b1, 16'h0002);
    issue(4'd15, 16'hFFFF, 16'h0004, 1'b0, 1'b0, 16'h0000);
    issue(4'd14, 16'h0050, 16'h1234, 1'b1, 1'b1, 16'h1234);

    // Condition table
    for (int i = 0; i < 17; i++) begin
      load_flags(tbl[i].flags);
      tp = 16'h0100 + 16'(i * 4);
      issue(tbl[i].cc, tp, 16'h0010, 1'b0, tbl[i].exp,
            tbl[i].exp ? (tp + 16'h0010) : (tp + 16'h0001));
    end
    check("psr_upper_ignored", {16'd0, psr}, 32'h0000);

    // Flag write during EVAL is forwarded and lands in PSR
    load_flags(16'h0000);
    wait_ready();
    cond      = 4'd0;
    pc        = 16'h0040;
    disp      = 16'h0008;
    absolute  = 1'b0;
    req_valid = 1'b1;
    sb_q.push_back('{taken: 1'b1, next_pc: 16'h0048});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    flag_in   = 16'h0008;
    flag_we   = 1'b1;
    @(posedge clk);
    #1;
    flag_we = 1'b0;
    check("fwd_resp_valid", {31'd0, resp_valid}, 32'd1);
    check("fwd_psr", {16'd0, psr}, 32'h0008);

    // Backpressure: response held stable, extra request ignored
    wait_ready();
    resp_ready = 1'b0;
    issue(4'd14, 16'h0060, 16'h0005, 1'b0, 1'b1, 16'h0065);
    cond      = 4'd15;
    pc        = 16'h0999;
    disp      = 16'h0001;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_resp_valid", {31'd0, resp_valid}, 32'd1);
      check("hold_taken", {31'd0, taken}, 32'd1);
      check("hold_next_pc", {16'd0, next_pc}, 32'h0065);
      check("hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hold_release_ready", {31'd0, req_ready}, 32'd1);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("hold_no_second_resp", {31'd0, resp_valid}, 32'd0);
    end

    // Reset during EVAL aborts the request
    load_flags(16'h001F);
    wait_ready();
    cond      = 4'd14;
    pc        = 16'h0070;
    disp      = 16'h0001;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst_n     = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("abort_psr", {16'd0, psr}, 32'h0000);
    check("abort_req_ready", {31'd0, req_ready}, 32'd1);
    repeat (4) begin
      @(posedge clk);
      #1;
      check("abort_no_resp", {31'd0, resp_valid}, 32'd0);
    end

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
